seq_divider16: RTL and testbench
================================

Name: seq_divider16

Overview:
- Sequential restoring divider for the MAC datapath. It performs unsigned division by repeated shift-and-subtract, one quotient bit per clock.
- It is the inverse counterpart of the accumulating adder path: it decomposes a value instead of building one up.
- Operands enter through a start/busy/done handshake. Quotient and remainder are held on registered outputs until the next accepted start.

Parameters:
- WIDTH, 16, operand width in bits (dividend, divisor, quotient, remainder); must be >= 2.

Ports:
- div_clk_i  input  1  clock; all state updates on the rising edge.
- div_reset_i  input  1  asynchronous active-high reset.
- start_i  input  1  request; sampled only when not busy.
- dividend_i  input  WIDTH  unsigned dividend; captured on the accepting edge.
- divisor_i  input  WIDTH  unsigned divisor; captured on the accepting edge.
- busy_o  output  1  high while an iteration is in progress.
- done_o  output  1  one-cycle pulse when the result becomes valid.
- quotient_o  output  WIDTH  registered quotient.
- remainder_o  output  WIDTH  registered remainder.
- div_by_zero_o  output  1  high with the result when the captured divisor was 0; held with the result.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. busy_o, done_o, quotient_o, remainder_o and div_by_zero_o are all 0. Iteration counter = 0.
- States:
  - IDLE: start_i=1 -> RUN.
  - RUN: counter reaches terminal -> DONE.
  - DONE: start_i=1 -> RUN; otherwise -> IDLE after one cycle.
- Accept edge (E0), taken in IDLE or DONE when start_i=1:
  - latch divisor;
  - Q register <= dividend_i;
  - partial remainder R <= 0;
  - counter <= WIDTH;
  - div_by_zero flag <= (divisor_i==0);
  - busy_o <= 1, done_o <= 0.
- Each RUN edge, one iteration, using a WIDTH+1 bit trial:
  - shift {R,Q} left by one (R takes Q MSB, Q LSB vacated);
  - T = R_shifted - divisor;
  - if T >= 0 (no borrow): R <= T, Q LSB <= 1; else R unchanged after the shift, Q LSB <= 0;
  - counter decrements.
- Latency:
  - the WIDTH-th RUN edge (E_WIDTH) completes the last iteration;
  - at E_WIDTH: state -> DONE, busy_o <= 0, done_o <= 1;
  - quotient_o <= Q, remainder_o <= R, div_by_zero_o <= flag;
  - busy_o is high for exactly WIDTH cycles; done_o is high in the cycle following E_WIDTH only.
- Result outputs are held stable from E_WIDTH until the edge that completes the next operation. They are not cleared by an accept.
- start_i while busy_o=1 is ignored. No queuing, no effect on the current operation.
- start_i asserted in the DONE cycle is accepted: done_o drops at that edge and busy_o rises at that edge (back-to-back, no idle gap).
- Divisor = 0 needs no special path and has the same latency: quotient_o = all ones, remainder_o = dividend, div_by_zero_o = 1.
- Dividend < divisor: quotient_o = 0, remainder_o = dividend.
- Invariant for divisor != 0: dividend == quotient_o*divisor + remainder_o, and remainder_o < divisor.
- Input changes on dividend_i/divisor_i after E0 have no effect on the current operation.
- Reset mid-operation aborts immediately. No done_o pulse; outputs return to 0.

Test Plan:
- Reset, then start with 100 / 7 -> busy_o high 16 cycles, done_o 1-cycle pulse; quotient_o=14, remainder_o=2, div_by_zero_o=0.
- 0xFFFF / 0x0001 and 0xFFFF / 0xFFFF -> q=0xFFFF r=0; q=1 r=0.
- 5 / 9 -> q=0 r=5. Then 0x1234 / 0 -> q=0xFFFF, r=0x1234, div_by_zero_o=1 with done_o.
- Start 1000 / 3; pulse start_i with 50 / 5 at cycle 5 of busy -> ignored; result q=333 r=1; no second done_o.
- start_i held during the done cycle with 81 / 9 -> immediate re-accept, busy_o rises with no gap; first result (prior op) visible in the done cycle; next done_o gives q=9 r=0.
- Assert div_reset_i at cycle 8 of 60000 / 7 -> all outputs 0 asynchronously, no done_o. After release, a new start of 60000 / 7 -> q=8571 r=3.

Source files
------------

// File: rtl/seq_divider16.sv
// Sequential restoring divider: unsigned WIDTH-bit division, one quotient
// bit per clock, start/busy/done handshake with held registered results.
module seq_divider16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             div_clk_i,
  input  logic             div_reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  // Counter must be able to hold the value WIDTH itself.
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Working registers of the current operation.
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quo_work_q, quo_work_d;
  logic [WIDTH-1:0] rem_work_q, rem_work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_flag_q, dbz_flag_d;

  // Registered handshake and result outputs.
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // One restoring step: shift {R,Q} left, trial-subtract the divisor.
  logic [WIDTH:0]   shift_c;
  logic [WIDTH:0]   trial_c;
  logic             fits_c;
  logic [WIDTH-1:0] rem_step_c;
  logic [WIDTH-1:0] quo_step_c;
  logic             accept_c;
  logic             last_iter_c;

  assign shift_c = {rem_work_q, quo_work_q[WIDTH-1]};
  assign trial_c = shift_c - {1'b0, divisor_q};
  assign fits_c  = (shift_c >= {1'b0, divisor_q});

  // Partial remainder stays below the divisor, so WIDTH bits always suffice.
  assign rem_step_c = fits_c ? WIDTH'(trial_c) : WIDTH'(shift_c);
  assign quo_step_c = {quo_work_q[WIDTH-2:0], fits_c};

  assign accept_c    = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_iter_c = (cnt_q == CNT_W'(1));

  // Next-state and datapath update decisions.
  always_comb begin
    state_d     = state_q;
    divisor_d   = divisor_q;
    quo_work_d  = quo_work_q;
    rem_work_d  = rem_work_q;
    cnt_d       = cnt_q;
    dbz_flag_d  = dbz_flag_q;
    busy_d      = busy_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_c) begin
          state_d    = S_RUN;
          divisor_d  = divisor_i;
          quo_work_d = dividend_i;
          rem_work_d = '0;
          cnt_d      = CNT_W'(WIDTH);
          dbz_flag_d = (divisor_i == '0);
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end

      S_RUN: begin
        quo_work_d = quo_step_c;
        rem_work_d = rem_step_c;
        cnt_d      = cnt_q - CNT_W'(1);
        if (last_iter_c) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = quo_step_c;
          remainder_d = rem_step_c;
          dbz_d       = dbz_flag_q;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge div_clk_i or posedge div_reset_i) begin
    if (div_reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Working datapath registers.
  always_ff @(posedge div_clk_i or posedge div_reset_i) begin
    if (div_reset_i) begin
      divisor_q  <= '0;
      quo_work_q <= '0;
      rem_work_q <= '0;
      cnt_q      <= '0;
      dbz_flag_q <= 1'b0;
    end else begin
      divisor_q  <= divisor_d;
      quo_work_q <= quo_work_d;
      rem_work_q <= rem_work_d;
      cnt_q      <= cnt_d;
      dbz_flag_q <= dbz_flag_d;
    end
  end

  // Handshake and held result registers.
  always_ff @(posedge div_clk_i or posedge div_reset_i) begin
    if (div_reset_i) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Bench for seq_divider16: arithmetic reference model checked every cycle,
// directed scenarios with literal results, then randomized operations.
module tb_seq_divider16;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy_o, done_o, dbz_o;
  logic [W-1:0]  quotient_o, remainder_o;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  seq_divider16 #(.WIDTH(W)) dut (
    .div_clk_i     (clk),
    .div_reset_i   (rst),
    .start_i       (start),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (dbz_o)
  );

  always #5 clk = ~clk;

  // Reference model: result computed with / and %, timing by cycle count.
  logic         m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0;
  logic [W-1:0] p_q = '0, p_r = '0;
  logic         p_dbz = 1'b0;
  int           m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_q = '0; m_r = '0; m_left = 0;
    end else if (!m_busy && start) begin
      m_busy = 1'b1;
      m_done = 1'b0;
      m_left = W;
      p_dbz  = (divisor == '0);
      p_q    = (divisor == '0) ? {W{1'b1}} : dividend / divisor;
      p_r    = (divisor == '0) ? dividend  : dividend % divisor;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_q = p_q; m_r = p_r; m_dbz = p_dbz;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    vectors++;
    if (busy_o !== m_busy || done_o !== m_done || quotient_o !== m_q ||
        remainder_o !== m_r || dbz_o !== m_dbz) begin
      miscompares++;
      $display("FAIL cycle_check t=%0t: got busy=%b done=%b q=%h r=%h dbz=%b, want busy=%b done=%b q=%h r=%h dbz=%b",
               $time, busy_o, done_o, quotient_o, remainder_o, dbz_o,
               m_busy, m_done, m_q, m_r, m_dbz);
    end
    if (done_o === 1'b1) done_cnt++;
  end

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", name, got, got, exp, exp);
    end
  endtask

  task automatic check_res(input string name, input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    check_val({name, "_q"}, 32'(quotient_o), 32'(q));
    check_val({name, "_r"}, 32'(remainder_o), 32'(r));
    check_val({name, "_dbz"}, 32'(dbz_o), 32'(z));
  endtask

  // Present an operation; 'now' drives start in the current (done) cycle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit now);
    if (!now) @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Wait for done_o with a cycle budget; also reports busy cycles seen.
  task automatic wait_done(input string name, output int nbusy);
    bit seen;
    seen  = 1'b0;
    nbusy = (busy_o === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy_o === 1'b1) nbusy++;
      if (done_o === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no done_o within 40 cycles, want done_o", name);
    end
  endtask

  initial begin
    int nb, d0;
    logic [W-1:0] a, b;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("reset_busy", 32'(busy_o), 0);
    check_val("reset_done", 32'(done_o), 0);
    check_res("reset", '0, '0, 1'b0);
    rst = 1'b0;

    // 100 / 7
    start_op(16'd100, 16'd7, 0);
    wait_done("op100_7", nb);
    check_val("op100_7_busy_cycles", 32'(nb), 32'(W));
    check_val("op100_7_done", 32'(done_o), 1);
    check_res("op100_7", 16'd14, 16'd2, 1'b0);
    @(negedge clk);
    check_val("op100_7_done_pulse", 32'(done_o), 0);
    check_res("op100_7_held", 16'd14, 16'd2, 1'b0);

    start_op(16'hFFFF, 16'h0001, 0);
    wait_done("ffff_1", nb);
    check_res("ffff_1", 16'hFFFF, 16'h0000, 1'b0);

    start_op(16'hFFFF, 16'hFFFF, 0);
    wait_done("ffff_ffff", nb);
    check_res("ffff_ffff", 16'h0001, 16'h0000, 1'b0);

    start_op(16'd5, 16'd9, 0);
    wait_done("op5_9", nb);
    check_res("op5_9", 16'd0, 16'd5, 1'b0);

    start_op(16'h1234, 16'h0000, 0);
    wait_done("div0", nb);
    check_val("div0_busy_cycles", 32'(nb), 32'(W));
    check_val("div0_done", 32'(done_o), 1);
    check_res("div0", 16'hFFFF, 16'h1234, 1'b1);

    // start pulse during busy must be ignored
    start_op(16'd1000, 16'd3, 0);
    repeat (4) @(negedge clk);
    dividend = 16'd50; divisor = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", nb);
    check_res("ignore", 16'd333, 16'd1, 1'b0);
    @(negedge clk);
    d0 = done_cnt;
    repeat (24) @(negedge clk);
    check_val("ignore_no_second_done", 32'(done_cnt - d0), 0);

    // back-to-back accept in the done cycle
    start_op(16'd200, 16'd7, 0);
    wait_done("b2b_first", nb);
    check_val("b2b_first_done", 32'(done_o), 1);
    check_res("b2b_first", 16'd28, 16'd4, 1'b0);
    start_op(16'd81, 16'd9, 1);
    check_val("b2b_busy_rise", 32'(busy_o), 1);
    check_val("b2b_done_drop", 32'(done_o), 0);
    check_res("b2b_held", 16'd28, 16'd4, 1'b0);
    wait_done("b2b_second", nb);
    check_val("b2b_busy_cycles", 32'(nb), 32'(W));
    check_res("b2b_second", 16'd9, 16'd0, 1'b0);

    // reset mid-operation
    start_op(16'd60000, 16'd7, 0);
    repeat (7) @(negedge clk);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check_val("midrst_busy", 32'(busy_o), 0);
    check_val("midrst_done", 32'(done_o), 0);
    check_res("midrst", '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_val("midrst_no_done", 32'(done_cnt - d0), 0);
    start_op(16'd60000, 16'd7, 0);
    wait_done("after_rst", nb);
    check_res("after_rst", 16'd8571, 16'd3, 1'b0);

    // randomized operations, occasionally re-accepted in the done cycle
    for (int k = 0; k < 300; k++) begin
      bit now;
      int sel;
      sel = $urandom_range(0, 7);
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 31)) : W'($urandom);
      if (sel == 0)      b = '0;
      else if (sel <= 2) b = W'($urandom_range(1, 15));
      else               b = W'($urandom);
      now = (k != 0) && ($urandom_range(0, 3) == 0) && (done_o === 1'b1);
      start_op(a, b, now);
      wait_done("rand", nb);
      if (nb != W) check_val("rand_busy_cycles", 32'(nb), 32'(W));
      if (b != '0 && done_o === 1'b1)
        check_val("rand_invariant", 32'(quotient_o) * 32'(b) + 32'(remainder_o), 32'(a));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
